countdown_timer: RTL and testbench

Programmable down-counting timer that consumes a loaded count and signals expiry. It is the counterpart of the free-running up-counter in the SoC components library: software or a peripheral FSM loads a duration, starts the timer, and receives a single-cycle expiry event plus a sticky pending flag with acknowledge. Typical users are watchdog, timeout and periodic-tick generation inside peripheral subsystems.

---
 rtl/countdown_timer.sv | 145 ++++++++++++++
 tb/tb_countdown_timer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-cycle expiry pulse, sticky pending/overrun flags and auto-reload.
// Optional prescaler is compiled in with `define COUNTDOWN_TIMER_PRESCALER_EN.
module countdown_timer #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [WIDTH-1:0]       load_value_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   auto_reload_i,
    input  logic [WIDTH-1:0]       reload_value_i,
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    input  logic [PRESC_WIDTH-1:0] presc_i,
`endif
    input  logic                   event_ack_i,
    output logic [WIDTH-1:0]       count_o,
    output logic                   running_o,
    output logic                   event_o,
    output logic                   pending_o,
    output logic                   overrun_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             event_q, event_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             expire;

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
`else
    // Without the prescaler PRESC_WIDTH sizes nothing; an invalid value has no effect.
    if (PRESC_WIDTH < 1) begin : g_presc_width_unused
    end
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        expire    = 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
        presc_cnt_d = presc_cnt_q;
        // >= rather than == so a lowered divider mid-run ticks at once instead of wrapping.
        tick        = (presc_cnt_q >= presc_i);
`else
        tick        = 1'b1;
`endif

        if (load_i) begin
            count_d = load_value_i;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
            presc_cnt_d = '0;
`endif
            if (state_q == RUN && load_value_i == '0) begin
                state_d = IDLE;
            end
        end else if (state_q == RUN) begin
            if (stop_i) begin
                state_d = IDLE;
            end else if (tick) begin
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
                presc_cnt_d = '0;
`endif
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else if (count_q == WIDTH'(1)) begin
                    expire = 1'b1;
                    if (auto_reload_i && reload_value_i != '0) begin
                        count_d = reload_value_i;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end else begin
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
                presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
`endif
            end
        end else if (start_i && count_q != '0) begin
            state_d = RUN;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
            presc_cnt_d = '0;
`endif
        end

        event_d = expire;

        // An ack landing on the expiry edge leaves pending set and overrun untouched.
        if (expire) begin
            pending_d = 1'b1;
        end else if (event_ack_i) begin
            pending_d = 1'b0;
        end

        if (expire && !event_ack_i && pending_q) begin
            overrun_d = 1'b1;
        end else if (event_ack_i && !expire) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            event_q     <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
            presc_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            event_q     <= event_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
            presc_cnt_q <= presc_cnt_d;
`endif
        end
    end

    assign count_o   = count_q;
    assign running_o = (state_q == RUN);
    assign event_o   = event_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each step drives inputs, queues the expected
// {count, running, event, pending, overrun} and compares it one clock later.
module tb_countdown_timer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] load_value_i = '0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        auto_reload_i = 1'b0;
    logic [15:0] reload_value_i = '0;
    logic [7:0]  presc_i = '0;
    logic        event_ack_i = 1'b0;
    logic [15:0] count_o;
    logic        running_o, event_o, pending_o, overrun_o;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    typedef struct packed {
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        sp;
        logic        ar;
        logic [15:0] rv;
        logic        ack;
        logic [7:0]  pr;
        logic [15:0] c;
        logic        r;
        logic        e;
        logic        p;
        logic        o;
    } step_t;

    logic [19:0] sb[$];

    countdown_timer #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_i         (load_i),
        .load_value_i   (load_value_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .auto_reload_i  (auto_reload_i),
        .reload_value_i (reload_value_i),
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
        .presc_i        (presc_i),
`endif
        .event_ack_i    (event_ack_i),
        .count_o        (count_o),
        .running_o      (running_o),
        .event_o        (event_o),
        .pending_o      (pending_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic step_t mk(input logic ld, input logic [15:0] lv, input logic st,
                                 input logic sp, input logic ar, input logic [15:0] rv,
                                 input logic ack, input logic [7:0] pr, input logic [15:0] c,
                                 input logic r, input logic e, input logic p, input logic o);
        step_t s;
        s = '{ld: ld, lv: lv, st: st, sp: sp, ar: ar, rv: rv, ack: ack, pr: pr,
              c: c, r: r, e: e, p: p, o: o};
        return s;
    endfunction

    task automatic apply(input step_t s);
        load_i         = s.ld;
        load_value_i   = s.lv;
        start_i        = s.st;
        stop_i         = s.sp;
        auto_reload_i  = s.ar;
        reload_value_i = s.rv;
        event_ack_i    = s.ack;
        presc_i        = s.pr;
        sb.push_back({s.c, s.r, s.e, s.p, s.o});
    endtask

    task automatic test_reset();
        logic [19:0] got, exp;
        #1 rst_i = 1'b1;
        sb.push_back(20'h0);
        #2;
        got = {count_o, running_o, event_o, pending_o, overrun_o};
        exp = sb.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL reset: got cnt=%0d flags=%b want cnt=%0d flags=%b", got[19:4], got[3:0], exp[19:4], exp[3:0]);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic();
        step_t s[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL basic[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_auto_reload();
        step_t s[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 3, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 3, 0, 0, 3, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 3, 1, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 2, 1, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 3, 1, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 3, 1, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 3, 0, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL auto_reload[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_zero_count();
        step_t s[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL zero_count[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_same_edge();
        step_t s[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0));
        s.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL same_edge[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1));
        s.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        step_t s[$];
        step_t t[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 3, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 3, 0, 0, 3, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 3, 1, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 2, 1, 0, 1, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL reset_mid_pre[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
        rst_i = 1'b1;
        sb.push_back(20'h0);
        #2;
        got = {count_o, running_o, event_o, pending_o, overrun_o};
        exp = sb.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL reset_mid_async: got cnt=%0d flags=%b want cnt=%0d flags=%b", got[19:4], got[3:0], exp[19:4], exp[3:0]);
        end
        #1 rst_i = 1'b0;
        t.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL reset_mid_post[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    task automatic test_prescaler();
        step_t s[$];
        logic [19:0] got, exp;
        s.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 10, 0, 0, 0, 0, 0, 5, 10, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 5, 10, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 10, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 10, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 10, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk_i); #1;
            got = {count_o, running_o, event_o, pending_o, overrun_o};
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL prescaler[%0d]: got cnt=%0d flags=%b want cnt=%0d flags=%b", i, got[19:4], got[3:0], exp[19:4], exp[3:0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_auto_reload();
        test_zero_count();
        test_same_edge();
        test_back_to_back();
        test_reset_mid_run();
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
        test_prescaler();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
